sim_axi_mem: RTL and testbench
==============================

SIM_AXI_MEM -- requirements
Module: sim_axi_mem

Interface
REQ-001 Parameter ADDR_BITS, default 32, AXI address width.
REQ-002 Parameter DATA_BITS, default 64, beat width; power of two, 32..512.
REQ-003 Parameter ID_BITS, default 5, transaction ID width.
REQ-004 Parameter DEPTH_WORDS, default 4096, number of DATA_BITS-wide storage words.
REQ-005 Parameter READ_LATENCY, default 4, cycles from AR handshake to first R beat valid; range 1..255.
REQ-006 clock  input  1  sole clock; all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 axi_aw_valid  input  1  write address valid.
REQ-009 axi_aw_ready  output  1  write address ready.
REQ-010 axi_aw_bits_addr  input  ADDR_BITS  write byte address.
REQ-011 axi_aw_bits_len  input  8  write beats minus one.
REQ-012 axi_aw_bits_burst  input  2  write burst type.
REQ-013 axi_aw_bits_id  input  ID_BITS  write ID.
REQ-014 axi_w_valid  input  1  write data valid.
REQ-015 axi_w_ready  output  1  write data ready.
REQ-016 axi_w_bits_data  input  DATA_BITS  write data.
REQ-017 axi_w_bits_strb  input  DATA_BITS/8  byte enables.
REQ-018 axi_w_bits_last  input  1  final write beat.
REQ-019 axi_b_valid  output  1  write response valid.
REQ-020 axi_b_ready  input  1  write response ready.
REQ-021 axi_b_bits_resp  output  2  write response code.
REQ-022 axi_b_bits_id  output  ID_BITS  write response ID.
REQ-023 axi_ar_valid  input  1  read address valid.
REQ-024 axi_ar_ready  output  1  read address ready.
REQ-025 axi_ar_bits_addr  input  ADDR_BITS  read byte address.
REQ-026 axi_ar_bits_len  input  8  read beats minus one.
REQ-027 axi_ar_bits_burst  input  2  read burst type.
REQ-028 axi_ar_bits_id  input  ID_BITS  read ID.
REQ-029 axi_r_valid  output  1  read data valid.
REQ-030 axi_r_ready  input  1  read data ready.
REQ-031 axi_r_bits_data  output  DATA_BITS  read data.
REQ-032 axi_r_bits_resp  output  2  read response code.
REQ-033 axi_r_bits_last  output  1  final read beat.
REQ-034 axi_r_bits_id  output  ID_BITS  read ID.

Function
REQ-035 Storage SHALL be a pure-RTL array, no DPI; word index = addr >> log2(DATA_BITS/8); low address bits ignored, each beat full width.
REQ-036 Write FSM SHALL have states W_IDLE (aw_ready=1), W_DATA (w_ready=1), W_RESP (b_valid=1); AW handshake latches addr/len/burst/id and enters W_DATA next cycle.
REQ-037 Each W handshake SHALL write strobed bytes to the current word; INCR (01) advances index by 1 per beat, FIXED (00) holds it; beat counter reaching len moves to W_RESP; b_valid held until b_ready, then W_IDLE.
REQ-038 Read FSM SHALL have states R_IDLE (ar_ready=1), R_WAIT, R_DATA; AR handshake loads counter with READ_LATENCY and r_valid rises exactly READ_LATENCY cycles after the handshake.
REQ-039 In R_DATA r_valid SHALL stay high with data/resp/last/id stable until r_ready; next beat presented the cycle after handshake, no bubbles; r_last=1 only on beat len; return to R_IDLE after last handshake.
REQ-040 Response codes: OKAY=0; burst WRAP(10)/reserved(11) SHALL give SLVERR=2 with no write and r_data=0; beat index >= DEPTH_WORDS SHALL give DECERR=3, write suppressed, r_data=0; B resp = worst code over burst; R resp per beat.
REQ-041 w_last mismatched with beat count (early or missing) SHALL force B resp SLVERR; burst still terminates on count len.
REQ-042 Read and write FSMs SHALL run concurrently; a read beat sampled the same cycle as a write to that word SHALL return pre-write data.

Reset
REQ-043 reset low SHALL asynchronously force both FSMs idle, all valid/ready outputs 0, resp/id/data/last outputs 0; in-flight bursts dropped with no B or R issued; storage contents unaffected.

Verification
REQ-044 INCR write len=3 at 0x100, strb all ones, then INCR read len=3 -> B OKAY once, four R beats match, r_last on 4th, first r_valid 4 cycles after AR.
REQ-045 Write 0x1122334455667788 then strb 0x0F with 0xAAAAAAAAAAAAAAAA to same word -> read returns 0x11223344AAAAAAAA.
REQ-046 FIXED write len=2 data 1,2,3 -> read returns 3; read at index DEPTH_WORDS -> r_resp 3, r_data 0.
REQ-047 r_ready low 5 cycles mid-burst -> r_data/r_last held stable, no beat lost or duplicated; simultaneous write/read bursts complete independently.
REQ-048 reset asserted in W_DATA after 2 of 4 beats -> all outputs 0 immediately, no b_valid after release, first 2 beats remain in storage.

Source files
------------

// File: rtl/sim_axi_mem.sv
// sim_axi_mem: behavioural-grade but synthesizable AXI4 slave memory for simulation.
// Purpose: word-addressed storage behind independent AXI write and read channels,
//          with a programmable read latency and per-beat error responses.
// Ports:
//   clock, reset (async, active-low)
//   AW  : axi_aw_valid/ready, addr, len, burst, id
//   W   : axi_w_valid/ready, data, strb, last
//   B   : axi_b_valid/ready, resp, id
//   AR  : axi_ar_valid/ready, addr, len, burst, id
//   R   : axi_r_valid/ready, data, resp, last, id
module sim_axi_mem #(
   parameter int unsigned ADDR_BITS    = 32,
   parameter int unsigned DATA_BITS    = 64,
   parameter int unsigned ID_BITS      = 5,
   parameter int unsigned DEPTH_WORDS  = 4096,
   parameter int unsigned READ_LATENCY = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   axi_aw_valid,
   output logic                   axi_aw_ready,
   input  logic [ADDR_BITS-1:0]   axi_aw_bits_addr,
   input  logic [7:0]             axi_aw_bits_len,
   input  logic [1:0]             axi_aw_bits_burst,
   input  logic [ID_BITS-1:0]     axi_aw_bits_id,
   input  logic                   axi_w_valid,
   output logic                   axi_w_ready,
   input  logic [DATA_BITS-1:0]   axi_w_bits_data,
   input  logic [DATA_BITS/8-1:0] axi_w_bits_strb,
   input  logic                   axi_w_bits_last,
   output logic                   axi_b_valid,
   input  logic                   axi_b_ready,
   output logic [1:0]             axi_b_bits_resp,
   output logic [ID_BITS-1:0]     axi_b_bits_id,
   input  logic                   axi_ar_valid,
   output logic                   axi_ar_ready,
   input  logic [ADDR_BITS-1:0]   axi_ar_bits_addr,
   input  logic [7:0]             axi_ar_bits_len,
   input  logic [1:0]             axi_ar_bits_burst,
   input  logic [ID_BITS-1:0]     axi_ar_bits_id,
   output logic                   axi_r_valid,
   input  logic                   axi_r_ready,
   output logic [DATA_BITS-1:0]   axi_r_bits_data,
   output logic [1:0]             axi_r_bits_resp,
   output logic                   axi_r_bits_last,
   output logic [ID_BITS-1:0]     axi_r_bits_id
);
   localparam int unsigned NBYTES = DATA_BITS / 8;
   localparam int unsigned OFFS   = $clog2(NBYTES);
   localparam int unsigned IDX_W  = ADDR_BITS - OFFS;
   localparam int unsigned MEM_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;
   localparam logic [1:0] BURST_INCR  = 2'd1;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

   logic [DATA_BITS-1:0] r_mem [DEPTH_WORDS];

   // Response for one beat: WRAP/reserved bursts beat out-of-range words.
   function automatic logic [1:0] beat_code(input logic [1:0] burst, input logic [IDX_W-1:0] idx);
      if (burst[1]) return RESP_SLVERR;
      if (64'(idx) >= 64'(DEPTH_WORDS)) return RESP_DECERR;
      return RESP_OKAY;
   endfunction

   // Byte-offset address bits carry no information for full-width beats.
   logic w_unused;
   assign w_unused = ^{axi_aw_bits_addr[OFFS-1:0], axi_ar_bits_addr[OFFS-1:0]};

   // ---------------- write channel ----------------
   wstate_t            r_wstate, w_wstate_nxt;
   logic [IDX_W-1:0]   r_widx, w_widx_nxt;
   logic [7:0]         r_wlen, w_wlen_nxt, r_wcnt, w_wcnt_nxt;
   logic [1:0]         r_wburst, w_wburst_nxt, r_wresp, w_wresp_nxt;
   logic [ID_BITS-1:0] r_wid, w_wid_nxt, r_b_id, w_b_id_nxt;
   logic [1:0]         r_b_resp, w_b_resp_nxt, w_wcode, w_wbeat_resp;
   logic               r_aw_ready, r_w_ready, r_b_valid;
   logic               w_wlast_exp, w_mem_we;

   // Write FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wstate   <= W_IDLE;
         r_widx     <= '0;
         r_wlen     <= '0;
         r_wcnt     <= '0;
         r_wburst   <= '0;
         r_wresp    <= '0;
         r_wid      <= '0;
         r_b_id     <= '0;
         r_b_resp   <= '0;
         r_aw_ready <= 1'b0;
         r_w_ready  <= 1'b0;
         r_b_valid  <= 1'b0;
      end else begin
         r_wstate   <= w_wstate_nxt;
         r_widx     <= w_widx_nxt;
         r_wlen     <= w_wlen_nxt;
         r_wcnt     <= w_wcnt_nxt;
         r_wburst   <= w_wburst_nxt;
         r_wresp    <= w_wresp_nxt;
         r_wid      <= w_wid_nxt;
         r_b_id     <= w_b_id_nxt;
         r_b_resp   <= w_b_resp_nxt;
         r_aw_ready <= (w_wstate_nxt == W_IDLE);
         r_w_ready  <= (w_wstate_nxt == W_DATA);
         r_b_valid  <= (w_wstate_nxt == W_RESP);
      end
   end

   // Write FSM next state; B resp accumulates the worst beat code.
   always_comb begin
      w_wstate_nxt = r_wstate;
      w_widx_nxt   = r_widx;
      w_wlen_nxt   = r_wlen;
      w_wcnt_nxt   = r_wcnt;
      w_wburst_nxt = r_wburst;
      w_wresp_nxt  = r_wresp;
      w_wid_nxt    = r_wid;
      w_b_id_nxt   = r_b_id;
      w_b_resp_nxt = r_b_resp;
      w_mem_we     = 1'b0;
      w_wcode      = beat_code(r_wburst, r_widx);
      w_wlast_exp  = (r_wcnt == r_wlen);
      w_wbeat_resp = r_wresp;
      case (r_wstate)
         W_IDLE: begin
            if (axi_aw_valid && r_aw_ready) begin
               w_widx_nxt   = IDX_W'(axi_aw_bits_addr >> OFFS);
               w_wlen_nxt   = axi_aw_bits_len;
               w_wburst_nxt = axi_aw_bits_burst;
               w_wid_nxt    = axi_aw_bits_id;
               w_wcnt_nxt   = 8'd0;
               w_wresp_nxt  = RESP_OKAY;
               w_wstate_nxt = W_DATA;
            end
         end
         W_DATA: begin
            if (axi_w_valid && r_w_ready) begin
               w_mem_we     = (w_wcode == RESP_OKAY);
               w_wbeat_resp = (w_wcode > r_wresp) ? w_wcode : r_wresp;
               // A misplaced or missing w_last is a protocol error, not a terminator.
               if ((axi_w_bits_last != w_wlast_exp) && (w_wbeat_resp < RESP_SLVERR))
                  w_wbeat_resp = RESP_SLVERR;
               w_wresp_nxt = w_wbeat_resp;
               if (w_wlast_exp) begin
                  w_wstate_nxt = W_RESP;
                  w_b_resp_nxt = w_wbeat_resp;
                  w_b_id_nxt   = r_wid;
               end else begin
                  w_wcnt_nxt = r_wcnt + 8'd1;
                  if (r_wburst == BURST_INCR) w_widx_nxt = r_widx + IDX_W'(1);
               end
            end
         end
         W_RESP: begin
            if (r_b_valid && axi_b_ready) begin
               w_wstate_nxt = W_IDLE;
               w_b_resp_nxt = '0;
               w_b_id_nxt   = '0;
            end
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   // Storage is never reset; strobed byte writes only.
   always_ff @(posedge clock) begin
      if (w_mem_we) begin
         for (int unsigned b = 0; b < NBYTES; b++) begin
            if (axi_w_bits_strb[b]) r_mem[MEM_W'(r_widx)][b*8 +: 8] <= axi_w_bits_data[b*8 +: 8];
         end
      end
   end

   // ---------------- read channel ----------------
   rstate_t              r_rstate, w_rstate_nxt;
   logic [IDX_W-1:0]     r_ridx, w_ridx_nxt, w_rsel;
   logic [7:0]           r_rlen, w_rlen_nxt, r_rcnt, w_rcnt_nxt, r_rlat, w_rlat_nxt;
   logic [1:0]           r_rburst, w_rburst_nxt, w_rcode;
   logic [ID_BITS-1:0]   r_rid, w_rid_nxt, r_r_id, w_r_id_nxt;
   logic [DATA_BITS-1:0] r_r_data, w_r_data_nxt, w_rword;
   logic [1:0]           r_r_resp, w_r_resp_nxt;
   logic                 r_r_last, w_r_last_nxt, r_ar_ready, r_r_valid;

   // Word feeding the next R beat: current index when leaving R_WAIT, advanced one in R_DATA.
   assign w_rsel  = (r_rstate == R_DATA) ? (r_ridx + IDX_W'(r_rburst == BURST_INCR)) : r_ridx;
   assign w_rcode = beat_code(r_rburst, w_rsel);
   assign w_rword = r_mem[MEM_W'(w_rsel)];

   // Read FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rstate   <= R_IDLE;
         r_ridx     <= '0;
         r_rlen     <= '0;
         r_rcnt     <= '0;
         r_rlat     <= '0;
         r_rburst   <= '0;
         r_rid      <= '0;
         r_r_id     <= '0;
         r_r_data   <= '0;
         r_r_resp   <= '0;
         r_r_last   <= 1'b0;
         r_ar_ready <= 1'b0;
         r_r_valid  <= 1'b0;
      end else begin
         r_rstate   <= w_rstate_nxt;
         r_ridx     <= w_ridx_nxt;
         r_rlen     <= w_rlen_nxt;
         r_rcnt     <= w_rcnt_nxt;
         r_rlat     <= w_rlat_nxt;
         r_rburst   <= w_rburst_nxt;
         r_rid      <= w_rid_nxt;
         r_r_id     <= w_r_id_nxt;
         r_r_data   <= w_r_data_nxt;
         r_r_resp   <= w_r_resp_nxt;
         r_r_last   <= w_r_last_nxt;
         r_ar_ready <= (w_rstate_nxt == R_IDLE);
         r_r_valid  <= (w_rstate_nxt == R_DATA);
      end
   end

   // Read FSM next state; a beat is loaded on the same edge as a write sees pre-write data.
   always_comb begin
      w_rstate_nxt = r_rstate;
      w_ridx_nxt   = r_ridx;
      w_rlen_nxt   = r_rlen;
      w_rcnt_nxt   = r_rcnt;
      w_rlat_nxt   = r_rlat;
      w_rburst_nxt = r_rburst;
      w_rid_nxt    = r_rid;
      w_r_id_nxt   = r_r_id;
      w_r_data_nxt = r_r_data;
      w_r_resp_nxt = r_r_resp;
      w_r_last_nxt = r_r_last;
      case (r_rstate)
         R_IDLE: begin
            if (axi_ar_valid && r_ar_ready) begin
               w_ridx_nxt   = IDX_W'(axi_ar_bits_addr >> OFFS);
               w_rlen_nxt   = axi_ar_bits_len;
               w_rburst_nxt = axi_ar_bits_burst;
               w_rid_nxt    = axi_ar_bits_id;
               w_rcnt_nxt   = 8'd0;
               w_rlat_nxt   = 8'(READ_LATENCY);
               w_rstate_nxt = R_WAIT;
            end
         end
         R_WAIT: begin
            if (r_rlat == 8'd1) begin
               w_rstate_nxt = R_DATA;
               w_r_data_nxt = (w_rcode == RESP_OKAY) ? w_rword : '0;
               w_r_resp_nxt = w_rcode;
               w_r_last_nxt = (r_rlen == 8'd0);
               w_r_id_nxt   = r_rid;
            end else begin
               w_rlat_nxt = r_rlat - 8'd1;
            end
         end
         R_DATA: begin
            if (r_r_valid && axi_r_ready) begin
               if (r_r_last) begin
                  w_rstate_nxt = R_IDLE;
                  w_r_data_nxt = '0;
                  w_r_resp_nxt = '0;
                  w_r_last_nxt = 1'b0;
                  w_r_id_nxt   = '0;
               end else begin
                  w_rcnt_nxt   = r_rcnt + 8'd1;
                  w_ridx_nxt   = w_rsel;
                  w_r_data_nxt = (w_rcode == RESP_OKAY) ? w_rword : '0;
                  w_r_resp_nxt = w_rcode;
                  w_r_last_nxt = ((r_rcnt + 8'd1) == r_rlen);
               end
            end
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   assign axi_aw_ready    = r_aw_ready;
   assign axi_w_ready     = r_w_ready;
   assign axi_b_valid     = r_b_valid;
   assign axi_b_bits_resp = r_b_resp;
   assign axi_b_bits_id   = r_b_id;
   assign axi_ar_ready    = r_ar_ready;
   assign axi_r_valid     = r_r_valid;
   assign axi_r_bits_data = r_r_data;
   assign axi_r_bits_resp = r_r_resp;
   assign axi_r_bits_last = r_r_last;
   assign axi_r_bits_id   = r_r_id;
endmodule

// File: tb/tb_sim_axi_mem.sv
// tb_sim_axi_mem: directed vector table plus hand-written multi-cycle sequences for sim_axi_mem.
module tb_sim_axi_mem;
   localparam int unsigned AW = 32, DW = 64, IW = 5, DEPTH = 4096, LAT = 4;
   localparam int LIM = 300;

   logic          clock = 1'b0, reset = 1'b0;
   logic          axi_aw_valid = 0, axi_aw_ready;
   logic [AW-1:0] axi_aw_bits_addr = '0;
   logic [7:0]    axi_aw_bits_len = '0;
   logic [1:0]    axi_aw_bits_burst = '0;
   logic [IW-1:0] axi_aw_bits_id = '0;
   logic          axi_w_valid = 0, axi_w_ready;
   logic [DW-1:0] axi_w_bits_data = '0;
   logic [DW/8-1:0] axi_w_bits_strb = '0;
   logic          axi_w_bits_last = 0;
   logic          axi_b_valid, axi_b_ready = 0;
   logic [1:0]    axi_b_bits_resp;
   logic [IW-1:0] axi_b_bits_id;
   logic          axi_ar_valid = 0, axi_ar_ready;
   logic [AW-1:0] axi_ar_bits_addr = '0;
   logic [7:0]    axi_ar_bits_len = '0;
   logic [1:0]    axi_ar_bits_burst = '0;
   logic [IW-1:0] axi_ar_bits_id = '0;
   logic          axi_r_valid, axi_r_ready = 0;
   logic [DW-1:0] axi_r_bits_data;
   logic [1:0]    axi_r_bits_resp;
   logic          axi_r_bits_last;
   logic [IW-1:0] axi_r_bits_id;

   sim_axi_mem #(.ADDR_BITS(AW), .DATA_BITS(DW), .ID_BITS(IW), .DEPTH_WORDS(DEPTH),
                 .READ_LATENCY(LAT)) dut (
      .clock(clock), .reset(reset),
      .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready), .axi_aw_bits_addr(axi_aw_bits_addr),
      .axi_aw_bits_len(axi_aw_bits_len), .axi_aw_bits_burst(axi_aw_bits_burst), .axi_aw_bits_id(axi_aw_bits_id),
      .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_bits_data(axi_w_bits_data),
      .axi_w_bits_strb(axi_w_bits_strb), .axi_w_bits_last(axi_w_bits_last),
      .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_bits_resp(axi_b_bits_resp),
      .axi_b_bits_id(axi_b_bits_id),
      .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_bits_addr(axi_ar_bits_addr),
      .axi_ar_bits_len(axi_ar_bits_len), .axi_ar_bits_burst(axi_ar_bits_burst), .axi_ar_bits_id(axi_ar_bits_id),
      .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_bits_data(axi_r_bits_data),
      .axi_r_bits_resp(axi_r_bits_resp), .axi_r_bits_last(axi_r_bits_last), .axi_r_bits_id(axi_r_bits_id)
   );

   always #5 clock = ~clock;

   int n_total = 0, n_pass = 0;
   logic [63:0] g_wdata [8];
   logic [7:0]  g_wstrb [8];
   logic [63:0] g_rdata [8];
   logic [1:0]  g_rresp [8];
   logic        g_rlast [8];
   logic [IW-1:0] g_rid [8];

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [IW-1:0] id);
      int t = 0;
      axi_aw_valid = 1; axi_aw_bits_addr = addr; axi_aw_bits_len = len;
      axi_aw_bits_burst = burst; axi_aw_bits_id = id;
      while (!axi_aw_ready && t < LIM) begin tick(); t++; end
      chk("aw_ready_seen", 64'(axi_aw_ready), 64'd1);
      tick();
      axi_aw_valid = 0;
   endtask

   task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
      int t = 0;
      axi_w_valid = 1; axi_w_bits_data = data; axi_w_bits_strb = strb; axi_w_bits_last = last;
      while (!axi_w_ready && t < LIM) begin tick(); t++; end
      chk("w_ready_seen", 64'(axi_w_ready), 64'd1);
      tick();
      axi_w_valid = 0; axi_w_bits_last = 0;
   endtask

   task automatic b_take(output logic [1:0] resp, output logic [IW-1:0] id);
      int t = 0;
      axi_b_ready = 1;
      while (!axi_b_valid && t < LIM) begin tick(); t++; end
      chk("b_valid_seen", 64'(axi_b_valid), 64'd1);
      resp = axi_b_bits_resp; id = axi_b_bits_id;
      tick();
      axi_b_ready = 0;
      chk("b_single", 64'(axi_b_valid), 64'd0);
   endtask

   // last_mode: 0 correct w_last, 1 w_last on first beat, 2 w_last never set
   task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                              input logic [IW-1:0] id, input int last_mode,
                              output logic [1:0] resp, output logic [IW-1:0] bid);
      aw_send(addr, len, burst, id);
      for (int i = 0; i <= int'(len); i++) begin
         logic lst;
         lst = (last_mode == 0) ? (i == int'(len)) : ((last_mode == 1) ? (i == 0) : 1'b0);
         w_send(g_wdata[i], g_wstrb[i], lst);
      end
      b_take(resp, bid);
   endtask

   task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [IW-1:0] id, input int stall_beat, input int stall_n,
                             output int lat);
      int t = 0;
      axi_ar_valid = 1; axi_ar_bits_addr = addr; axi_ar_bits_len = len;
      axi_ar_bits_burst = burst; axi_ar_bits_id = id;
      while (!axi_ar_ready && t < LIM) begin tick(); t++; end
      chk("ar_ready_seen", 64'(axi_ar_ready), 64'd1);
      tick();
      axi_ar_valid = 0;
      lat = 0;
      while (!axi_r_valid && lat < LIM) begin tick(); lat++; end
      for (int i = 0; i <= int'(len); i++) begin
         chk("r_valid_beat", 64'(axi_r_valid), 64'd1);
         if (i == stall_beat) begin
            logic [63:0] d0;
            logic        l0;
            d0 = axi_r_bits_data; l0 = axi_r_bits_last;
            axi_r_ready = 0;
            repeat (stall_n) tick();
            chk("stall_data", axi_r_bits_data, d0);
            chk("stall_last_valid", 64'({axi_r_bits_last, axi_r_valid}), 64'({l0, 1'b1}));
         end
         g_rdata[i] = axi_r_bits_data; g_rresp[i] = axi_r_bits_resp;
         g_rlast[i] = axi_r_bits_last; g_rid[i]   = axi_r_bits_id;
         axi_r_ready = 1;
         tick();
         axi_r_ready = 0;
      end
      chk("r_no_extra", 64'(axi_r_valid), 64'd0);
   endtask

   typedef struct packed {
      logic        do_wr;
      logic [31:0] addr;
      logic [1:0]  wburst;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
      logic [1:0]  exp_b;
      logic [1:0]  rburst;
      logic [63:0] exp_r;
      logic [1:0]  exp_rr;
   } vec_t;

   vec_t vecs [11];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0]    bresp;
      logic [IW-1:0] bid;
      int            lat;
      logic          seen_b;

      vecs[0]  = '{1'b1, 32'h200,  2'd1, 64'h1122334455667788, 8'hFF, 2'd0, 2'd1, 64'h1122334455667788, 2'd0};
      vecs[1]  = '{1'b1, 32'h200,  2'd1, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 2'd0, 2'd1, 64'h11223344AAAAAAAA, 2'd0};
      vecs[2]  = '{1'b1, 32'h200,  2'd1, 64'h5555555555555555, 8'hF0, 2'd0, 2'd1, 64'h55555555AAAAAAAA, 2'd0};
      vecs[3]  = '{1'b1, 32'h200,  2'd1, 64'hFFFFFFFFFFFFFFFF, 8'h00, 2'd0, 2'd1, 64'h55555555AAAAAAAA, 2'd0};
      vecs[4]  = '{1'b1, 32'h300,  2'd1, 64'hDEADBEEF01234567, 8'hFF, 2'd0, 2'd1, 64'hDEADBEEF01234567, 2'd0};
      vecs[5]  = '{1'b1, 32'h300,  2'd2, 64'h0123456789ABCDEF, 8'hFF, 2'd2, 2'd2, 64'h0,               2'd2};
      vecs[6]  = '{1'b0, 32'h305,  2'd1, 64'h0,                8'h00, 2'd0, 2'd1, 64'hDEADBEEF01234567, 2'd0};
      vecs[7]  = '{1'b1, 32'h300,  2'd3, 64'h0123456789ABCDEF, 8'hFF, 2'd2, 2'd3, 64'h0,               2'd2};
      vecs[8]  = '{1'b0, 32'h300,  2'd0, 64'h0,                8'h00, 2'd0, 2'd0, 64'hDEADBEEF01234567, 2'd0};
      vecs[9]  = '{1'b1, 32'h7FF8, 2'd1, 64'hCAFEF00D12345678, 8'hFF, 2'd0, 2'd1, 64'hCAFEF00D12345678, 2'd0};
      vecs[10] = '{1'b1, 32'h8000, 2'd1, 64'h1111111111111111, 8'hFF, 2'd3, 2'd1, 64'h0,               2'd3};

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      chk("rst_ctrl", 64'({axi_aw_ready, axi_w_ready, axi_b_valid, axi_ar_ready, axi_r_valid, axi_r_bits_last}), 64'd0);
      chk("rst_data", {axi_r_bits_data[63:8], 3'b0, axi_r_bits_id}, 64'd0);
      reset = 1;
      tick(); tick();
      chk("idle_ready", 64'({axi_aw_ready, axi_ar_ready, axi_w_ready, axi_b_valid}), 64'b1100);

      // Single-beat vector table
      for (int i = 0; i < 11; i++) begin
         if (vecs[i].do_wr) begin
            g_wdata[0] = vecs[i].wdata; g_wstrb[0] = vecs[i].wstrb;
            write_burst(vecs[i].addr, 8'd0, vecs[i].wburst, IW'(i), 0, bresp, bid);
            chk($sformatf("v%0d_bresp", i), 64'(bresp), 64'(vecs[i].exp_b));
            chk($sformatf("v%0d_bid", i), 64'(bid), 64'(i));
         end
         read_burst(vecs[i].addr, 8'd0, vecs[i].rburst, IW'(i + 16), -1, 0, lat);
         chk($sformatf("v%0d_lat", i), 64'(lat), 64'(LAT));
         chk($sformatf("v%0d_rdata", i), g_rdata[0], vecs[i].exp_r);
         chk($sformatf("v%0d_rresp_last", i), 64'({g_rresp[0], g_rlast[0]}), 64'({vecs[i].exp_rr, 1'b1}));
      end

      // INCR len=3 write/read at 0x100
      for (int i = 0; i < 4; i++) begin
         g_wdata[i] = 64'hC0DE000000001000 + 64'h0000000100000001 * 64'(i); g_wstrb[i] = 8'hFF;
      end
      write_burst(32'h100, 8'd3, 2'd1, 5'd7, 0, bresp, bid);
      chk("incr_bresp", 64'(bresp), 64'd0);
      chk("incr_bid", 64'(bid), 64'd7);
      read_burst(32'h100, 8'd3, 2'd1, 5'd9, -1, 0, lat);
      chk("incr_lat", 64'(lat), 64'(LAT));
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("incr_d%0d", i), g_rdata[i], 64'hC0DE000000001000 + 64'h0000000100000001 * 64'(i));
         chk($sformatf("incr_rlid%0d", i), 64'({g_rresp[i], g_rlast[i], g_rid[i]}), 64'({2'd0, (i == 3), 5'd9}));
      end

      // Stall mid-burst
      read_burst(32'h100, 8'd3, 2'd1, 5'd2, 2, 5, lat);
      for (int i = 0; i < 4; i++)
         chk($sformatf("stall_d%0d_last", i), {g_rdata[i][62:0], g_rlast[i]},
             {(64'hC0DE000000001000 + 64'h0000000100000001 * 64'(i)) << 1} | 64'(i == 3));

      // FIXED burst keeps the last beat
      g_wdata[0] = 64'd1; g_wdata[1] = 64'd2; g_wdata[2] = 64'd3;
      g_wstrb[0] = 8'hFF; g_wstrb[1] = 8'hFF; g_wstrb[2] = 8'hFF;
      write_burst(32'h400, 8'd2, 2'd0, 5'd1, 0, bresp, bid);
      chk("fixed_bresp", 64'(bresp), 64'd0);
      read_burst(32'h400, 8'd0, 2'd1, 5'd1, -1, 0, lat);
      chk("fixed_rdata", g_rdata[0], 64'd3);

      // w_last early / missing: SLVERR, burst still ends on count
      g_wdata[0] = 64'h0A0A; g_wdata[1] = 64'h0B0B;
      write_burst(32'h500, 8'd1, 2'd1, 5'd3, 1, bresp, bid);
      chk("early_last_bresp", 64'(bresp), 64'd2);
      g_wdata[0] = 64'h0C0C; g_wdata[1] = 64'h0D0D;
      write_burst(32'h500, 8'd1, 2'd1, 5'd4, 2, bresp, bid);
      chk("missing_last_bresp", 64'(bresp), 64'd2);
      read_burst(32'h500, 8'd1, 2'd1, 5'd4, -1, 0, lat);
      chk("missing_last_d", {g_rdata[1][31:0], g_rdata[0][31:0]}, 64'h00000D0D00000C0C);

      // Concurrent write and read bursts
      for (int i = 0; i < 4; i++) begin
         g_wdata[i] = 64'h5800 + 64'(i); g_wstrb[i] = 8'hFF;
      end
      fork
         write_burst(32'h580, 8'd3, 2'd1, 5'd11, 0, bresp, bid);
         read_burst(32'h100, 8'd3, 2'd1, 5'd12, -1, 0, lat);
      join
      chk("conc_bresp_id", 64'({bresp, bid}), 64'({2'd0, 5'd11}));
      chk("conc_rd3", g_rdata[3], 64'hC0DE000300001003);
      read_burst(32'h580, 8'd3, 2'd1, 5'd13, -1, 0, lat);
      chk("conc_wr_d0", g_rdata[0], 64'h5800);
      chk("conc_wr_d3", g_rdata[3], 64'h5803);

      // Read beat loaded on the same edge as a write to that word sees old data
      chk("raw_idle", 64'({axi_ar_ready, axi_aw_ready}), 64'b11);
      axi_ar_valid = 1; axi_ar_bits_addr = 32'h200; axi_ar_bits_len = 0;
      axi_ar_bits_burst = 2'd1; axi_ar_bits_id = 5'd3;
      tick();
      axi_ar_valid = 0;
      tick(); tick();
      axi_aw_valid = 1; axi_aw_bits_addr = 32'h200; axi_aw_bits_len = 0;
      axi_aw_bits_burst = 2'd1; axi_aw_bits_id = 5'd4;
      axi_w_valid = 1; axi_w_bits_data = 64'h0F0F0F0F0F0F0F0F; axi_w_bits_strb = 8'hFF; axi_w_bits_last = 1;
      tick();
      axi_aw_valid = 0;
      tick();
      axi_w_valid = 0; axi_w_bits_last = 0;
      chk("raw_rvalid", 64'(axi_r_valid), 64'd1);
      chk("raw_old_data", axi_r_bits_data, 64'h55555555AAAAAAAA);
      axi_r_ready = 1;
      tick();
      axi_r_ready = 0;
      b_take(bresp, bid);
      chk("raw_bresp", 64'(bresp), 64'd0);
      read_burst(32'h200, 8'd0, 2'd1, 5'd3, -1, 0, lat);
      chk("raw_new_data", g_rdata[0], 64'h0F0F0F0F0F0F0F0F);

      // Reset in W_DATA after 2 of 4 beats
      aw_send(32'h600, 8'd3, 2'd1, 5'd5);
      w_send(64'h6000AAAA, 8'hFF, 1'b0);
      w_send(64'h6001BBBB, 8'hFF, 1'b0);
      #2;
      reset = 0;
      #1;
      chk("rst_mid_ctrl", 64'({axi_aw_ready, axi_w_ready, axi_b_valid, axi_ar_ready, axi_r_valid}), 64'd0);
      chk("rst_mid_b", 64'({axi_b_bits_resp, axi_b_bits_id}), 64'd0);
      tick(); tick();
      reset = 1;
      axi_b_ready = 1;
      seen_b = 0;
      repeat (10) begin
         tick();
         seen_b = seen_b | axi_b_valid;
      end
      axi_b_ready = 0;
      chk("rst_no_b", 64'(seen_b), 64'd0);
      read_burst(32'h600, 8'd1, 2'd1, 5'd6, -1, 0, lat);
      chk("rst_kept_d0", g_rdata[0], 64'h6000AAAA);
      chk("rst_kept_d1", g_rdata[1], 64'h6001BBBB);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
